// File: rtl/edge_event_arbiter.sv
// Multi-channel edge detector: captures rising/falling edges per channel into a
// single pending slot each, then serializes them round-robin onto one valid/ready stream.
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_data_in,
  input  logic [NUM_CH-1:0] i_rise_en,
  input  logic [NUM_CH-1:0] i_fall_en,
  output logic              o_evt_valid,
  input  logic              i_evt_ready,
  output logic [CH_W-1:0]   o_evt_ch,
  output logic              o_evt_rise,
  output logic [NUM_CH-1:0] o_overflow,
  input  logic              i_ovf_clr
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   r_prev;
  logic                r_primed;
  logic [NUM_CH-1:0]   r_pending;
  logic [NUM_CH-1:0]   r_ptype;
  logic [NUM_CH-1:0]   r_overflow;
  logic [CH_W-1:0]     r_last;
  logic                r_evt_valid;
  logic [CH_W-1:0]     r_evt_ch;
  logic                r_evt_rise;

  logic [NUM_CH-1:0]   w_rise;
  logic [NUM_CH-1:0]   w_fall;
  logic [NUM_CH-1:0]   w_edge;
  logic [NUM_CH-1:0]   w_load_mask;
  logic [NUM_CH-1:0]   w_take;
  logic [NUM_CH-1:0]   w_ovf_set;
  logic [NUM_CH-1:0]   w_pending_nxt;
  logic [NUM_CH-1:0]   w_ptype_nxt;
  logic [NUM_CH-1:0]   w_overflow_nxt;
  logic                w_gnt_vld;
  logic [CH_W-1:0]     w_gnt_ch;
  logic                w_load;

  assign o_evt_valid = r_evt_valid;
  assign o_evt_ch    = r_evt_ch;
  assign o_evt_rise  = r_evt_rise;
  assign o_overflow  = r_overflow;

  // Edge detection is suppressed until prev holds a real sample after reset.
  always_comb begin
    w_rise = {NUM_CH{1'b0}};
    w_fall = {NUM_CH{1'b0}};
    if (r_primed) begin
      w_rise = i_data_in & ~r_prev & i_rise_en;
      w_fall = ~i_data_in & r_prev & i_fall_en;
    end else begin
      w_rise = {NUM_CH{1'b0}};
      w_fall = {NUM_CH{1'b0}};
    end
    w_edge = w_rise | w_fall;
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = {CH_W{1'b0}};
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!w_gnt_vld && r_pending[CH_W'((int'(r_last) + i) % NUM_CH)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = CH_W'((int'(r_last) + i) % NUM_CH);
      end else begin
        w_gnt_vld = w_gnt_vld;
      end
    end
  end

  // Output FSM: decides whether the granted channel is loaded this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_load      = 1'b1;
          w_state_nxt = ST_PRESENT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (i_evt_ready && w_gnt_vld) begin
          w_load      = 1'b1;
          w_state_nxt = ST_PRESENT;
        end else if (i_evt_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PRESENT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A slot being loaded this cycle can absorb a new edge without overflowing.
  always_comb begin
    w_load_mask    = w_load ? ({{(NUM_CH-1){1'b0}}, 1'b1} << w_gnt_ch) : {NUM_CH{1'b0}};
    w_take         = w_edge & (~r_pending | w_load_mask);
    w_ovf_set      = w_edge & r_pending & ~w_load_mask;
    w_pending_nxt  = (r_pending & ~w_load_mask) | w_edge;
    w_ptype_nxt    = (r_ptype & ~w_take) | (w_rise & w_take);
    w_overflow_nxt = (r_overflow & ~{NUM_CH{i_ovf_clr}}) | w_ovf_set;
  end

  // State, pending slots and the registered output stream.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_prev      <= {NUM_CH{1'b0}};
      r_primed    <= 1'b0;
      r_pending   <= {NUM_CH{1'b0}};
      r_ptype     <= {NUM_CH{1'b0}};
      r_overflow  <= {NUM_CH{1'b0}};
      r_last      <= CH_W'(NUM_CH - 1);
      r_evt_valid <= 1'b0;
      r_evt_ch    <= {CH_W{1'b0}};
      r_evt_rise  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= i_data_in;
      r_primed    <= 1'b1;
      r_pending   <= w_pending_nxt;
      r_ptype     <= w_ptype_nxt;
      r_overflow  <= w_overflow_nxt;
      r_evt_valid <= (w_state_nxt == ST_PRESENT);
      if (w_load) begin
        r_evt_ch   <= w_gnt_ch;
        r_evt_rise <= r_ptype[w_gnt_ch];
        r_last     <= w_gnt_ch;
      end else begin
        r_evt_ch   <= r_evt_ch;
        r_evt_rise <= r_evt_rise;
        r_last     <= r_last;
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: expected events are queued when edges are
// driven and compared as each event is accepted on the output stream.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic [3:0] rise_en;
  logic [3:0] fall_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic [3:0] overflow;
  logic       ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] sb_q[$];

  edge_event_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_data_in   (data_in),
    .i_rise_en   (rise_en),
    .i_fall_en   (fall_en),
    .o_evt_valid (evt_valid),
    .i_evt_ready (evt_ready),
    .o_evt_ch    (evt_ch),
    .o_evt_rise  (evt_rise),
    .o_overflow  (overflow),
    .i_ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_evt(input logic [1:0] ch, input logic rise);
    sb_q.push_back({ch, rise});
  endtask

  // Every handshake seen before the next edge must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_evt", 32'(sb_q.size()), 32'd1);
      end else begin
        check_eq("sb_evt", {29'd0, evt_ch, evt_rise}, {29'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1; data_in = 4'b0001; rise_en = 4'hF; fall_en = 4'h1;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    check_eq("rst_valid", 32'(evt_valid), 32'd0);
    check_eq("rst_ch", 32'(evt_ch), 32'd0);
    check_eq("rst_rise", 32'(evt_rise), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);

    // priming: line already high must not raise an event
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_eq("prime_valid", 32'(evt_valid), 32'd0);
    end
    data_in = 4'b0000; push_evt(2'd0, 1'b0);
    tick(1);
    check_eq("lat_k_valid", 32'(evt_valid), 32'd0);
    tick(1);
    check_eq("lat_k1_valid", 32'(evt_valid), 32'd1);
    check_eq("lat_ch", 32'(evt_ch), 32'd0);
    check_eq("lat_rise", 32'(evt_rise), 32'd0);
    evt_ready = 1'b1;
    tick(1);
    check_eq("lat_done", 32'(evt_valid), 32'd0);

    // round-robin from a fresh reset
    evt_ready = 1'b0; reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    data_in = 4'hF;
    for (int c = 0; c < 4; c++) push_evt(2'(c), 1'b1);
    tick(2);
    check_eq("rr_first_ch", 32'(evt_ch), 32'd0);
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("rr_valid", 32'(evt_valid), 32'd1);
    end
    tick(1);
    check_eq("rr_drop", 32'(evt_valid), 32'd0);

    // fairness: last=1, ch0 and ch3 pending -> ch3 first
    fall_en = 4'h0;
    tick(1);
    data_in = 4'b0000;
    tick(2);
    data_in = 4'b0010; push_evt(2'd1, 1'b1);
    tick(3);
    evt_ready = 1'b0;
    data_in = 4'b1011; push_evt(2'd3, 1'b1); push_evt(2'd0, 1'b1);
    tick(2);
    check_eq("fair_ch", 32'(evt_ch), 32'd3);
    evt_ready = 1'b1;
    tick(3);
    check_eq("fair_idle", 32'(evt_valid), 32'd0);

    // overflow: second edge on a pending channel is dropped
    data_in = 4'b0000;
    tick(2);
    evt_ready = 1'b0;
    data_in = 4'b0100; push_evt(2'd2, 1'b1);
    tick(2);
    fall_en = 4'b0010;
    data_in = 4'b0110; push_evt(2'd1, 1'b1);
    tick(2);
    data_in = 4'b0100;
    tick(2);
    check_eq("ovf_set", 32'(overflow), 32'h2);
    evt_ready = 1'b1;
    tick(3);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(overflow), 32'h0);

    // same-cycle load and new edge on the same channel
    evt_ready = 1'b0;
    data_in = 4'b0000;
    tick(1);
    data_in = 4'b0100; push_evt(2'd2, 1'b1);
    tick(2);
    data_in = 4'b0110; push_evt(2'd1, 1'b1);
    tick(1);
    evt_ready = 1'b1;
    data_in = 4'b0100; push_evt(2'd1, 1'b0);
    tick(4);
    check_eq("same_no_ovf", 32'(overflow), 32'h0);
    check_eq("same_idle", 32'(evt_valid), 32'd0);

    // backpressure then reset discards presented and pending events
    evt_ready = 1'b0;
    data_in = 4'b1110;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_eq("bp_valid", 32'(evt_valid), 32'd1);
      check_eq("bp_ch", 32'(evt_ch), 32'd3);
      check_eq("bp_rise", 32'(evt_rise), 32'd1);
    end
    reset = 1'b1;
    tick(1);
    check_eq("mid_rst_valid", 32'(evt_valid), 32'd0);
    reset = 1'b0; evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check_eq("no_stale", 32'(evt_valid), 32'd0);
    end
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
